sync_par_updn_cntr: RTL
=======================

SYNC_PAR_UPDN_CNTR -- requirements
Module: sync_par_updn_cntr

Interface
REQ-001 The block SHALL have parameter `WIDTH`, default 8: counter width in bits, legal range 2..32.
REQ-002 The block SHALL have parameter `MAX_VAL`, default 2**WIDTH-1: terminal (modulus-1) value, legal range 1..2**WIDTH-1.
REQ-003 The block SHALL have port `clk`, input, 1 bit: clock; all state changes on its rising edge.
REQ-004 The block SHALL have port `rstn`, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port `clr`, input, 1 bit: synchronous clear.
REQ-006 The block SHALL have port `load`, input, 1 bit: synchronous parallel load of `d`.
REQ-007 The block SHALL have port `cnt_en`, input, 1 bit: count enable.
REQ-008 The block SHALL have port `cin`, input, 1 bit: cascade carry-in; tie high when standalone.
REQ-009 The block SHALL have port `up`, input, 1 bit: direction; 1 = increment, 0 = decrement.
REQ-010 The block SHALL have port `oneshot`, input, 1 bit: mode; 1 = stop at terminal, 0 = free-run wrap.
REQ-011 The block SHALL have port `d`, input, `WIDTH` bits: parallel load value.
REQ-012 The block SHALL have port `cmp`, input, `WIDTH` bits: compare value.
REQ-013 The block SHALL have port `count`, output, `WIDTH` bits: registered counter value.
REQ-014 The block SHALL have port `cout`, output, 1 bit: combinational cascade carry-out.
REQ-015 The block SHALL have port `tc_pulse`, output, 1 bit: registered one-cycle terminal event pulse.
REQ-016 The block SHALL have port `done`, output, 1 bit: sticky one-shot completion flag.
REQ-017 The block SHALL have port `match`, output, 1 bit: combinational flag, `count == cmp`.

Function
REQ-018 Per-edge priority SHALL be: `clr` > `load` > count step > hold.
REQ-019 `clr` SHALL set `count` = 0 and `done` = 0.
REQ-020 `load` SHALL set `count` = `d`, saturated to `MAX_VAL` when `d` > `MAX_VAL`, and SHALL clear `done`.
REQ-021 A step SHALL occur only when `cnt_en`=1, `cin`=1, `load`=0, `clr`=0, and NOT (`oneshot`=1 AND `done`=1).
REQ-022 The terminal value SHALL be `MAX_VAL` when `up`=1 and 0 when `up`=0.
REQ-023 A step at non-terminal SHALL give `count` ± 1, modulo-free; no intermediate wrap is possible below `MAX_VAL`.
REQ-024 A step at terminal with `oneshot`=0 SHALL wrap: up gives 0, down gives `MAX_VAL`.
REQ-025 A step at terminal with `oneshot`=1 SHALL hold `count` and set `done`=1; `done` stays set until `clr`, `load` or reset.
REQ-026 `cout` SHALL equal `cin` & `cnt_en` & (`count` == terminal) & ~`done`, purely combinational, zero latency, for ripple-enable cascading.
REQ-027 `tc_pulse` SHALL be 1 for exactly the one cycle following each edge on which a step occurred at terminal (wrap or one-shot stop).
REQ-028 `tc_pulse` SHALL be 0 after a `clr`/`load` edge.
REQ-029 A `count` value above `MAX_VAL` SHALL be unreachable.
REQ-030 A direction change mid-count SHALL take effect on the next step, with no extra cycle.
REQ-031 `load` with `cnt_en`=1 on the same edge SHALL load only, with no step.
REQ-032 `clr` and `load` on the same edge SHALL clear only.
REQ-033 `match` SHALL be independent of enables and SHALL be valid whenever `count` equals `cmp`.

Reset
REQ-034 Asserting `rstn`=0 SHALL immediately set `count`=0, `tc_pulse`=0, `done`=0, regardless of `clk`.
REQ-035 Reset deassertion SHALL be synchronised externally.
REQ-036 The first step SHALL occur on the first qualifying rising edge after `rstn` rises.
REQ-037 Reset mid-count SHALL discard the count in progress and any pending `tc_pulse`.

Structure
REQ-038 Shared package `cntr_pkg` SHALL hold the direction constants `CNT_UP`/`CNT_DN` and the action enum `{ACT_HOLD, ACT_CLR, ACT_LOAD, ACT_STEP}` used by the priority decode.
REQ-039 One combinational sub-module `cntr_next_val` SHALL compute the next count, the terminal flag and the wrap value from `count`, `up`, `oneshot` and `MAX_VAL`; the top level SHALL hold the registers, `done`, `tc_pulse`, `cout` and `match`.

Verification (WIDTH=8, MAX_VAL=9)
REQ-040 Reset, then `up`=1, `cnt_en`=`cin`=1, `oneshot`=0 for 12 cycles -> `count` SHALL go 1..9,0,1,2; `cout`=1 while `count`=9; `tc_pulse`=1 in the cycle `count` shows 0.
REQ-041 `load` `d`=3, then `up`=0 for 5 cycles -> `count` SHALL go 2,1,0,9,8; `tc_pulse` SHALL follow the 0->9 wrap.
REQ-042 `oneshot`=1, `up`=1, load 7, count 4 cycles -> `count` SHALL go 8,9,9,9; `done`=1 from the third edge; `tc_pulse` SHALL be a single pulse; then `load` `d`=2 -> `done`=0, `count`=2.
REQ-043 `load` `d`=200 -> `count`=9; the same edge with `clr`=1 and `load`=1 -> `count`=0.
REQ-044 Two instances cascaded (lo.`cout` -> hi.`cin`), 100 enabled cycles from 0 -> {hi,lo} SHALL read 0,0 with hi stepping only when lo=9.
REQ-045 `rstn` pulsed low mid-cycle at `count`=5 -> `count`=0 with no clock edge; `cmp`=0 -> `match`=1.

Source files
------------

// File: rtl/cntr_pkg.sv
// Shared constants and types for the parallel-load up/down counter.
// Direction encoding and the per-edge action decode live here.
package cntr_pkg;

  localparam logic CNT_UP = 1'b1;
  localparam logic CNT_DN = 1'b0;

  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_CLR,
    ACT_LOAD,
    ACT_STEP
  } act_e;

endpackage

// File: rtl/cntr_next_val.sv
// Next-count arithmetic: terminal detect, wrap target and one-shot hold.
// Purely combinational; the caller decides whether a step happens.
module cntr_next_val
  import cntr_pkg::*;
#(
  parameter int              WIDTH   = 8,
  parameter logic [WIDTH-1:0] MAX_VAL = '1
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up,
  input  logic             oneshot,
  output logic [WIDTH-1:0] next_val,
  output logic             at_term
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] term_val;
  logic [WIDTH-1:0] wrap_val;
  logic [WIDTH-1:0] step_val;

  always_comb begin
    term_val = '0;
    wrap_val = MAX_VAL;
    step_val = count - ONE;
    if (up == CNT_UP) begin
      term_val = MAX_VAL;
      wrap_val = '0;
      step_val = count + ONE;
    end
  end

  assign at_term = (count == term_val);

  always_comb begin
    next_val = step_val;
    if (at_term) begin
      next_val = oneshot ? count : wrap_val;
    end
  end

endmodule

// File: rtl/sync_par_updn_cntr.sv
// Synchronous up/down counter with clear, saturating load, one-shot
// mode, cascade carry, terminal pulse and compare match.
module sync_par_updn_cntr
  import cntr_pkg::*;
#(
  parameter int              WIDTH   = 8,
  parameter logic [WIDTH-1:0] MAX_VAL = '1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             load,
  input  logic             cnt_en,
  input  logic             cin,
  input  logic             up,
  input  logic             oneshot,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] cmp,
  output logic [WIDTH-1:0] count,
  output logic             cout,
  output logic             tc_pulse,
  output logic             done,
  output logic             match
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             done_q, done_d;
  logic             tc_q, tc_d;

  logic [WIDTH-1:0] next_val;
  logic             at_term;
  logic [WIDTH-1:0] load_val;
  logic             step_ok;
  act_e             act;

  cntr_next_val #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL)
  ) u_next (
    .count    (count_q),
    .up       (up),
    .oneshot  (oneshot),
    .next_val (next_val),
    .at_term  (at_term)
  );

  // Extra MSB keeps the compare meaningful when MAX_VAL is all-ones.
  assign load_val =
    ({1'b0, d} > {1'b0, MAX_VAL}) ? MAX_VAL : d;

  assign step_ok = cnt_en & cin & ~(oneshot & done_q);

  always_comb begin
    act = ACT_HOLD;
    unique case (1'b1)
      clr:                     act = ACT_CLR;
      (~clr & load):           act = ACT_LOAD;
      (~clr & ~load & step_ok): act = ACT_STEP;
      default:                 act = ACT_HOLD;
    endcase
  end

  always_comb begin
    count_d = count_q;
    done_d  = done_q;
    tc_d    = 1'b0;
    unique case (act)
      ACT_CLR: begin
        count_d = '0;
        done_d  = 1'b0;
      end
      ACT_LOAD: begin
        count_d = load_val;
        done_d  = 1'b0;
      end
      ACT_STEP: begin
        count_d = next_val;
        tc_d    = at_term;
        done_d  = done_q | (at_term & oneshot);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
      done_q  <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      done_q  <= done_d;
      tc_q    <= tc_d;
    end
  end

  assign count    = count_q;
  assign done     = done_q;
  assign tc_pulse = tc_q;
  assign cout     = cin & cnt_en & at_term & ~done_q;
  assign match    = (count_q == cmp);

endmodule
